// File: rtl/avalon_aes_multi_interface.sv
// avalon_aes_multi_interface
//   Avalon-MM slave that shares one AES decryption core between NUM_CH
//   key/ciphertext channels. A round-robin dispatcher grants pending channels
//   and stores each plaintext in that channel's read-only registers.
//
// Ports
//   CLK, RESET            clock, asynchronous active-high reset
//   AVL_*                 Avalon-MM slave, word address {channel, reg[3:0]},
//                         registered read data (latency 1)
//   EXPORT_DATA           {dec[127:112], dec[15:0]} of last completed job
//   CORE_START/KEY/MSG_ENC  level request to the AES core for the granted channel
//   CORE_DONE/MSG_DEC     core completion and plaintext
//   IRQ                   done & irq_en interrupt; live only when the macro
//                         AES_MULTI_IRQ_EN is defined, otherwise tied low
module avalon_aes_multi_interface #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = $clog2(NUM_CH) + 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic              AVL_CS,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [31:0]       AVL_WRITEDATA,
  output logic [31:0]       AVL_READDATA,
  output logic [31:0]       EXPORT_DATA,
  output logic              CORE_START,
  output logic [127:0]      CORE_KEY,
  output logic [127:0]      CORE_MSG_ENC,
  input  logic              CORE_DONE,
  input  logic [127:0]      CORE_MSG_DEC,
  output logic              IRQ
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       key_q [NUM_CH];
  logic [127:0]       key_d [NUM_CH];
  logic [127:0]       enc_q [NUM_CH];
  logic [127:0]       enc_d [NUM_CH];
  logic [127:0]       dec_q [NUM_CH];
  logic [127:0]       dec_d [NUM_CH];
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [3:0]         last_done_q, last_done_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        export_q, export_d;
`ifdef AES_MULTI_IRQ_EN
  logic [NUM_CH-1:0]  irq_en_q, irq_en_d;
  logic               irq_q, irq_d;
`endif

  logic [ADDR_W-1:0]  ch_raw;
  logic [IDX_W-1:0]   ch_sel;
  logic [3:0]         reg_sel;
  logic               ch_ok, wr_en, locked, irq_en_rd;
  logic [31:0]        be_mask;
  logic               found;
  logic [IDX_W-1:0]   pick;
  int unsigned        idx;

  assign ch_raw  = AVL_ADDR >> 4;
  assign ch_sel  = IDX_W'(ch_raw);
  assign reg_sel = AVL_ADDR[3:0];
  assign ch_ok   = 32'(ch_raw) < NUM_CH;
  assign wr_en   = AVL_CS && AVL_WRITE && ch_ok;
  assign locked  = pending_q[ch_sel] | busy_q[ch_sel];
  assign be_mask = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}},
                    {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};

`ifdef AES_MULTI_IRQ_EN
  assign irq_en_rd = irq_en_q[ch_sel];
`else
  assign irq_en_rd = 1'b0;
`endif

  // Word 0 is the most significant 32 bits of the 128-bit value.
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] w);
    case (w)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] w,
                                            input logic [31:0] d, input logic [31:0] m);
    logic [127:0] r;
    r = v;
    case (w)
      2'd0:    r[127:96] = (v[127:96] & ~m) | (d & m);
      2'd1:    r[95:64]  = (v[95:64]  & ~m) | (d & m);
      2'd2:    r[63:32]  = (v[63:32]  & ~m) | (d & m);
      default: r[31:0]   = (v[31:0]   & ~m) | (d & m);
    endcase
    return r;
  endfunction

  // Bus writes are applied before the dispatcher so that a capture setting
  // done overrides a same-edge W1C, and a grant clears pending last.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    enc_d        = enc_q;
    dec_d        = dec_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    done_d       = done_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    last_done_d  = last_done_q;
    rdata_d      = rdata_q;
    export_d     = export_q;
    found        = 1'b0;
    pick         = last_grant_q;
    idx          = 0;
`ifdef AES_MULTI_IRQ_EN
    irq_en_d     = irq_en_q;
    irq_d        = |(done_q & irq_en_q);
`endif

    if (wr_en) begin
      case (reg_sel[3:2])
        2'b00: if (!locked)
          key_d[ch_sel] = put_word(key_q[ch_sel], reg_sel[1:0], AVL_WRITEDATA, be_mask);
        2'b01: if (!locked)
          enc_d[ch_sel] = put_word(enc_q[ch_sel], reg_sel[1:0], AVL_WRITEDATA, be_mask);
        default: ;
      endcase
      if (reg_sel == 4'd14 && AVL_BYTE_EN[0] && AVL_WRITEDATA[0] && !locked) begin
        pending_d[ch_sel] = 1'b1;
        done_d[ch_sel]    = 1'b0;
      end
      if (reg_sel == 4'd15 && AVL_BYTE_EN[0]) begin
        if (AVL_WRITEDATA[0]) done_d[ch_sel] = 1'b0;
`ifdef AES_MULTI_IRQ_EN
        irq_en_d[ch_sel] = AVL_WRITEDATA[3];
`endif
      end
    end

    case (state_q)
      S_IDLE: begin
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
          idx = 32'(last_grant_q) + k;
          if (idx >= NUM_CH) idx = idx - NUM_CH;
          if (!found && pending_q[IDX_W'(idx)]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
          end
        end
        if (found) begin
          pending_d[pick] = 1'b0;
          busy_d[pick]    = 1'b1;
          grant_d         = pick;
          state_d         = S_BUSY;
        end
      end
      S_BUSY: if (CORE_DONE) begin
        dec_d[grant_q]  = CORE_MSG_DEC;
        done_d[grant_q] = 1'b1;
        busy_d[grant_q] = 1'b0;
        last_grant_d    = grant_q;
        last_done_d     = 4'(grant_q);
        export_d        = {CORE_MSG_DEC[127:112], CORE_MSG_DEC[15:0]};
        state_d         = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (AVL_CS && AVL_READ) begin
      rdata_d = '0;
      if (ch_ok) begin
        case (reg_sel[3:2])
          2'b00: rdata_d = word_of(key_q[ch_sel], reg_sel[1:0]);
          2'b01: rdata_d = word_of(enc_q[ch_sel], reg_sel[1:0]);
          2'b10: rdata_d = word_of(dec_q[ch_sel], reg_sel[1:0]);
          default: begin
            case (reg_sel[1:0])
              2'b00:   rdata_d = {20'd0, last_done_q, 8'(NUM_CH)};
              2'b11:   rdata_d = {28'd0, irq_en_rd, busy_q[ch_sel],
                                  pending_q[ch_sel], done_q[ch_sel]};
              default: rdata_d = '0;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      key_q        <= '{default: '0};
      enc_q        <= '{default: '0};
      dec_q        <= '{default: '0};
      pending_q    <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_CH - 1);
      last_done_q  <= '0;
      rdata_q      <= '0;
      export_q     <= '0;
`ifdef AES_MULTI_IRQ_EN
      irq_en_q     <= '0;
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      enc_q        <= enc_d;
      dec_q        <= dec_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      last_done_q  <= last_done_d;
      rdata_q      <= rdata_d;
      export_q     <= export_d;
`ifdef AES_MULTI_IRQ_EN
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
`endif
    end
  end

  assign AVL_READDATA = rdata_q;
  assign EXPORT_DATA  = export_q;
  assign CORE_START   = (state_q == S_BUSY);
  assign CORE_KEY     = key_q[grant_q];
  assign CORE_MSG_ENC = enc_q[grant_q];
`ifdef AES_MULTI_IRQ_EN
  assign IRQ          = irq_q;
`else
  assign IRQ          = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_aes_multi_interface.sv
`timescale 1ns/1ps
module tb_avalon_aes_multi_interface;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 6;
`ifdef AES_MULTI_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam logic [127:0] MASK = {4{32'h5A5A5A5A}};
  localparam logic [127:0] K0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] E0 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] K1 = {32'h00FF00FF, 32'h12000000, 64'h0};
  localparam logic [127:0] K2 = {32'h22222222, 96'h0};
  localparam logic [127:0] K3 = {32'h33333333, 96'h0};

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              AVL_READ = 1'b0;
  logic              AVL_WRITE = 1'b0;
  logic              AVL_CS = 1'b0;
  logic [3:0]        AVL_BYTE_EN = '0;
  logic [ADDR_W-1:0] AVL_ADDR = '0;
  logic [31:0]       AVL_WRITEDATA = '0;
  logic [31:0]       AVL_READDATA;
  logic [31:0]       EXPORT_DATA;
  logic              CORE_START;
  logic [127:0]      CORE_KEY;
  logic [127:0]      CORE_MSG_ENC;
  logic              CORE_DONE;
  logic [127:0]      CORE_MSG_DEC;
  logic              IRQ;

  avalon_aes_multi_interface #(.NUM_CH(NUM_CH)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .EXPORT_DATA(EXPORT_DATA), .CORE_START(CORE_START), .CORE_KEY(CORE_KEY),
    .CORE_MSG_ENC(CORE_MSG_ENC), .CORE_DONE(CORE_DONE),
    .CORE_MSG_DEC(CORE_MSG_DEC), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Core model: plaintext = key ^ ciphertext ^ MASK after core_lat cycles.
  int           core_lat = 20;
  int           core_cnt = 0;
  int           jobs_started = 0;
  int           jobs_done = 0;
  int           low_run = 0;
  logic [127:0] job_keys[$];
  int           gaps[$];

  initial begin
    CORE_DONE    = 1'b0;
    CORE_MSG_DEC = '0;
    forever begin
      @(negedge CLK);
      if (!CORE_START) begin
        CORE_DONE = 1'b0;
        core_cnt  = 0;
        low_run++;
      end else if (!CORE_DONE) begin
        if (core_cnt == 0) begin
          job_keys.push_back(CORE_KEY);
          gaps.push_back(low_run);
          low_run = 0;
          jobs_started++;
        end
        core_cnt++;
        if (core_cnt >= core_lat) begin
          CORE_MSG_DEC = CORE_KEY ^ CORE_MSG_ENC ^ MASK;
          CORE_DONE    = 1'b1;
          jobs_done++;
        end
      end
    end
  end

  function automatic logic [5:0] A(input int ch, input int r);
    return 6'(ch * 16 + r);
  endfunction

  task automatic bus_write_now(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_BYTE_EN = be; AVL_WRITEDATA = d;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge CLK);
    bus_write_now(a, be, d);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  // Returns half a cycle before the edge that samples CORE_DONE.
  task automatic wait_core_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK); #1;
      if (CORE_DONE) begin
        seen = 1'b1;
        break;
      end
    end
    check({nm, " done timeout"}, seen, 1'b1);
  endtask

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vw(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.be = be; v.data = d; v.exp = '0;
    return v;
  endfunction

  function automatic vec_t vr(input logic [5:0] a, input logic [31:0] e);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.be = '0; v.data = '0; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [31:0]  rd;
    logic [127:0] pt;
    int           base;
    bit           ok;

    vecs.push_back(vw(A(0, 0), 4'hF, 32'h00010203));
    vecs.push_back(vw(A(0, 1), 4'hF, 32'h04050607));
    vecs.push_back(vw(A(0, 2), 4'hF, 32'h08090A0B));
    vecs.push_back(vw(A(0, 3), 4'hF, 32'h0C0D0E0F));
    vecs.push_back(vw(A(0, 4), 4'hF, 32'h00112233));
    vecs.push_back(vw(A(0, 5), 4'hF, 32'h44556677));
    vecs.push_back(vw(A(0, 6), 4'hF, 32'h8899AABB));
    vecs.push_back(vw(A(0, 7), 4'hF, 32'hCCDDEEFF));
    vecs.push_back(vr(A(0, 0), 32'h00010203));
    vecs.push_back(vr(A(0, 3), 32'h0C0D0E0F));
    vecs.push_back(vr(A(0, 6), 32'h8899AABB));
    vecs.push_back(vw(A(1, 0), 4'b0101, 32'hFFFFFFFF));
    vecs.push_back(vr(A(1, 0), 32'h00FF00FF));
    vecs.push_back(vw(A(1, 1), 4'b1000, 32'h12345678));
    vecs.push_back(vr(A(1, 1), 32'h12000000));
    vecs.push_back(vw(A(1, 8), 4'hF, 32'h12345678));
    vecs.push_back(vr(A(1, 8), 32'h00000000));
    vecs.push_back(vr(A(2, 12), 32'h00000004));
    vecs.push_back(vw(A(1, 13), 4'hF, 32'hFFFFFFFF));
    vecs.push_back(vr(A(1, 13), 32'h00000000));
    vecs.push_back(vr(A(0, 14), 32'h00000000));
    vecs.push_back(vw(A(1, 15), 4'hF, 32'h00000008));
    vecs.push_back(vr(A(1, 15), IRQ_ON ? 32'h8 : 32'h0));
    vecs.push_back(vw(A(1, 15), 4'hF, 32'h00000000));
    vecs.push_back(vr(A(1, 15), 32'h00000000));
    vecs.push_back(vw(A(2, 0), 4'hF, 32'h22222222));
    vecs.push_back(vw(A(3, 0), 4'hF, 32'h33333333));
    vecs.push_back(vr(A(3, 0), 32'h33333333));
    vecs.push_back(vr(A(2, 1), 32'h00000000));

    // Reset state
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK); #1;
    check("rst readdata", AVL_READDATA, 32'h0);
    check("rst export", EXPORT_DATA, 32'h0);
    check("rst core_start", CORE_START, 1'b0);
    check("rst core_key", CORE_KEY, 128'h0);
    check("rst irq", IRQ, 1'b0);
    bus_read(A(0, 15), rd); check("rst status", rd, 32'h0);
    bus_read(A(0, 12), rd); check("rst info", rd, 32'h4);

    // Register map vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].be, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Single job on ch0
    core_lat = 20;
    bus_write(A(0, 14), 4'hF, 32'h1);
    check("single start low at N", CORE_START, 1'b0);
    @(posedge CLK); #1;
    check("single start high at N+1", CORE_START, 1'b1);
    check("single core_key", CORE_KEY, K0);
    check("single core_enc", CORE_MSG_ENC, E0);
    bus_read(A(0, 15), rd); check("single status busy", rd, 32'h4);
    wait_core_done("single");
    pt = K0 ^ E0 ^ MASK;
    for (int w = 0; w < 4; w++) begin
      bus_read(A(0, 8 + w), rd);
      check($sformatf("single pt w%0d", w), rd, pt[127 - 32 * w -: 32]);
    end
    bus_read(A(0, 15), rd); check("single status done", rd, 32'h1);
    check("single export", EXPORT_DATA, {pt[127:112], pt[15:0]});

    // Round robin: start ch2, ch0, ch3 on consecutive edges
    job_keys.delete();
    gaps.delete();
    base = jobs_done;
    bus_write(A(2, 14), 4'hF, 32'h1);
    bus_write(A(0, 14), 4'hF, 32'h1);
    bus_write(A(3, 14), 4'hF, 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK); #1;
      if (jobs_done >= base + 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("rr completes", ok, 1'b1);
    check("rr job count", job_keys.size(), 3);
    check("rr grant0", job_keys.size() > 0 ? job_keys[0] : 128'h0, K2);
    check("rr grant1", job_keys.size() > 1 ? job_keys[1] : 128'h0, K3);
    check("rr grant2", job_keys.size() > 2 ? job_keys[2] : 128'h0, K0);
    check("rr gap1 >= 2", gaps.size() > 1 && gaps[1] >= 2, 1'b1);
    check("rr gap2 >= 2", gaps.size() > 2 && gaps[2] >= 2, 1'b1);
    bus_read(A(1, 12), rd); check("rr info last ch0", rd, 32'h004);
    pt = K3 ^ MASK;
    bus_read(A(3, 8), rd); check("rr ch3 pt w0", rd, pt[127:96]);

    // Lockout while ch1 busy
    core_lat = 30;
    base = jobs_started;
    bus_write(A(1, 14), 4'hF, 32'h1);
    @(posedge CLK); #1;
    check("lock start high", CORE_START, 1'b1);
    bus_write(A(1, 0), 4'hF, 32'hDEADBEEF);
    bus_write(A(1, 14), 4'hF, 32'h1);
    bus_read(A(1, 0), rd); check("lock key unchanged", rd, 32'h00FF00FF);
    bus_read(A(1, 15), rd); check("lock status busy only", rd, 32'h4);
    check("lock core_key stable", CORE_KEY, K1);
    wait_core_done("lock");
    repeat (10) @(posedge CLK);
    #1;
    check("lock no second job", jobs_started, base + 1);
    check("lock start idle", CORE_START, 1'b0);
    bus_read(A(1, 15), rd); check("lock status done", rd, 32'h1);

    // W1C on done colliding with the capture edge
    core_lat = 5;
    bus_write(A(0, 14), 4'hF, 32'h1);
    wait_core_done("collide");
    bus_write_now(A(0, 15), 4'hF, 32'h1);
    bus_read(A(0, 15), rd); check("collide set wins", rd, 32'h1);
    bus_write(A(0, 15), 4'hF, 32'h1);
    bus_read(A(0, 15), rd); check("w1c clears", rd, 32'h0);

    // IRQ on ch3
    bus_write(A(3, 15), 4'hF, 32'h9);
    bus_read(A(3, 15), rd); check("irq_en readback", rd, IRQ_ON ? 32'h8 : 32'h0);
    check("irq low before job", IRQ, 1'b0);
    bus_write(A(3, 14), 4'hF, 32'h1);
    wait_core_done("irq");
    @(posedge CLK); #1;
    check("irq lags done", IRQ, 1'b0);
    @(posedge CLK); #1;
    check("irq raised", IRQ, IRQ_ON);
    bus_write(A(3, 15), 4'hF, 32'h9);
    check("irq held at w1c edge", IRQ, IRQ_ON);
    @(posedge CLK); #1;
    check("irq dropped", IRQ, 1'b0);

    // Reset in the middle of a job
    core_lat = 20;
    bus_write(A(1, 14), 4'hF, 32'h1);
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    check("mid busy before reset", CORE_START, 1'b1);
    RESET = 1'b1;
    #1;
    check("async start drop", CORE_START, 1'b0);
    check("reset core_key", CORE_KEY, 128'h0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus_read(A(c, 15), rd);
      check($sformatf("post-reset status ch%0d", c), rd, 32'h0);
    end
    bus_write(A(2, 14), 4'hF, 32'h1);
    check("post-reset start low at N", CORE_START, 1'b0);
    @(posedge CLK); #1;
    check("post-reset start high", CORE_START, 1'b1);
    wait_core_done("post-reset");
    bus_read(A(2, 15), rd); check("post-reset done", rd, 32'h1);
    bus_read(A(0, 12), rd); check("post-reset info", rd, 32'h204);
    bus_read(A(2, 8), rd); check("post-reset pt", rd, 32'h5A5A5A5A);
    check("post-reset export", EXPORT_DATA, 32'h5A5A5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/avalon_aes_multi_interface.md
# avalon_aes_multi_interface

Avalon-MM slave that fronts a single shared AES decryption core with `NUM_CH` independent key/message channels. Software loads a key and ciphertext per channel and writes a start bit. A round-robin dispatcher then time-shares the core across pending channels, captures each plaintext into that channel's read-only registers, and raises per-channel done flags. The block sits between the Avalon-MM system interconnect and the AES core, and supersedes the single-channel interface.

## Interface
- `NUM_CH`, 4: number of channels; legal range 1–16.
- `ADDR_W`, `$clog2(NUM_CH)+4`: Avalon word-address width (derived; do not override).
- `CLK` in 1: Avalon clock; all logic on rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `AVL_READ` in 1: Avalon-MM read.
- `AVL_WRITE` in 1: Avalon-MM write.
- `AVL_CS` in 1: chip select; reads and writes are ignored when low.
- `AVL_BYTE_EN` in 4: write byte enables.
- `AVL_ADDR` in `ADDR_W`: word address; `[ADDR_W-1:4]` is the channel, `[3:0]` is the register.
- `AVL_WRITEDATA` in 32: write data.
- `AVL_READDATA` out 32: registered read data, read latency 1.
- `EXPORT_DATA` out 32: `{dec[127:112], dec[15:0]}` of the most recently completed channel.
- `CORE_START` out 1: level start to the AES core; held high until `CORE_DONE`.
- `CORE_KEY` out 128: key of the granted channel; stable while `CORE_START` is high.
- `CORE_MSG_ENC` out 128: ciphertext of the granted channel; stable while `CORE_START` is high.
- `CORE_DONE` in 1: core completion (level).
- `CORE_MSG_DEC` in 128: core plaintext; valid while `CORE_DONE` is high.
- `IRQ` out 1: interrupt output; present only with `AES_MULTI_IRQ_EN`.

## Operation
- Per-channel register map, at word offset `ch*16`:
  - 0–3: key, word 0 = `[127:96]`, R/W with byte enables.
  - 4–7: ciphertext, same ordering, R/W with byte enables.
  - 8–11: plaintext, read-only; writes ignored.
  - 12: global info, RO. `[7:0]` = `NUM_CH`, `[11:8]` = last completed channel. Identical in every channel.
  - 13: reserved; reads 0.
  - 14: start. Writing 1 to bit0 sets `pending`. Self-clearing; reads 0.
  - 15: status. `[0]` done (W1C), `[1]` pending, `[2]` busy, `[3]` irq_en (R/W, only with macro).
- Channels with `ch >= NUM_CH`: reads return 0; writes are ignored.
- A channel is locked while `pending` or `busy` is set:
  - Writes to its key/ciphertext are ignored.
  - A start write is ignored.
- A start write on an unlocked channel sets `pending` and clears `done` in the same edge.
- Dispatcher FSM:
  - **IDLE**: if any channel is pending, grant the first pending channel searching upward from `last_grant+1` (mod `NUM_CH`). On the grant, clear its `pending`, set its `busy`, latch the grant index, and go to BUSY.
  - **BUSY**: `CORE_START`=1, `CORE_KEY`/`CORE_MSG_ENC` come from the granted channel. On `CORE_DONE`=1: write `CORE_MSG_DEC` into the channel's words 8–11, set `done`, clear `busy`, update `last_grant` and the last-completed index, and go to RELEASE.
  - **RELEASE**: `CORE_START`=0 for one cycle so the core returns to idle, then go to IDLE.
- After reset, `last_grant` = `NUM_CH-1`, so channel 0 has the highest priority first.
- A W1C write to `done` in the same edge that the capture sets it: the set wins.
- Reset values:
  - All registers, `AVL_READDATA`, `EXPORT_DATA`, `CORE_START`, `CORE_KEY`, `CORE_MSG_ENC` and `IRQ` are 0.
  - FSM in IDLE.
  - Reset mid-operation aborts the job, clears all pending/busy/done, and drops `CORE_START` immediately (asynchronous).

## Timing
- Read: address sampled at edge N; `AVL_READDATA` is valid after edge N and holds until the next read.
- Write: takes effect at the sampling edge. Status reflects the write on the next cycle.
- Start write at edge N:
  - `pending`=1 after N.
  - Grant at N+1, `CORE_START`=1 after N+1 (idle core).
- Dispatch latency: `CORE_DONE` sampled at edge M gives plaintext and `done` visible after M; a read issued at M+1 returns them.
- Back-to-back jobs: minimum 2 cycles of `CORE_START` low between jobs (RELEASE, IDLE).

## Configuration
- `AES_MULTI_IRQ_EN` defined:
  - Status bit 3 per channel is a R/W `irq_en`.
  - `IRQ` = OR over channels of (`done` & `irq_en`), registered, so it rises one cycle after `done`.
- Not defined:
  - Bit 3 reads 0 and ignores writes.
  - `IRQ` is tied to 0; no interrupt logic is synthesised.

## Test plan
- **Single job:** load ch0 key `000102..0F` and ciphertext, start; core model returns `CORE_DONE` after 20 cycles. Required: `CORE_START` rises 2 edges after the write; `CORE_KEY` equals the loaded key; words 8–11 hold the model plaintext; status reads `0x1`.
- **Round robin:** start ch2, ch0 and ch3 in consecutive cycles while the core is idle. Required: grant order 2, 3, 0; each job is separated by ≥2 cycles of `CORE_START` low.
- **Lockout:** while ch1 is busy, write its key word 0 = `0xDEADBEEF` and write start again. Required: the key is unchanged, no second job is queued, and `CORE_KEY` stays stable.
- **Done W1C and collision:** write 1 to ch0 status bit0 in the same cycle as its capture. Required: `done` reads 1. A later W1C gives 0.
- **Reset mid-job:** assert `RESET` during BUSY. Required: `CORE_START` falls asynchronously, all status reads 0 after release, and the next start dispatches normally.
- **IRQ (macro on):** ch3 `irq_en`=1; on completion `IRQ` rises one cycle after `done`; W1C on `done` drops `IRQ` next cycle. With the macro off, `IRQ` stays 0.
